// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues in-order imem reads, buffers returned
// instructions with their PCs in a prefetch FIFO, and flushes on execute-stage redirects.
module fetch_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,

  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,

  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,

  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,

  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] CreditLimit = (CntW + 1)'(DEPTH);

  typedef enum logic [0:0] {StFetch, StDrain} state_e;

  state_e            state;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   outstanding_q, outstanding_d;
  logic [CntW-1:0]   discard_cnt_q, discard_cnt_d;
  logic [31:0]       mem_instr_q [DEPTH];
  logic [31:0]       mem_pc_q    [DEPTH];

  logic [CntW-1:0]   count;
  logic [CntW:0]     credit_sum;
  logic              fifo_empty;
  logic              req_fire;
  logic              rsp_accept;
  logic              rsp_push;
  logic              pop;
  logic [31:0]       redirect_target;
  logic [PtrW-1:0]   wr_idx;
  logic [PtrW-1:0]   rd_idx;
  logic              unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_addr[1:0];
  assign redirect_target      = {redirect_addr[31:2], 2'b00};
  assign count                = wr_ptr_q - rd_ptr_q;
  assign fifo_empty           = (count == '0);
  assign wr_idx               = wr_ptr_q[PtrW-1:0];
  assign rd_idx               = rd_ptr_q[PtrW-1:0];

  // Handshake decode. Credits count buffered plus in-flight fetches; a same-cycle pop is
  // deliberately not credited so a push can never land on a full FIFO.
  always_comb begin
    state          = (discard_cnt_q != '0) ? StDrain : StFetch;
    credit_sum     = {1'b0, count} + {1'b0, outstanding_q};
    imem_req_valid = !reset && !redirect_valid && (credit_sum < CreditLimit);
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol violation and is ignored.
    rsp_accept     = imem_rsp_valid && (outstanding_q != '0);
    rsp_push       = rsp_accept && !redirect_valid && (state == StFetch);
    out_valid      = !fifo_empty;
    pop            = out_valid && out_ready && !redirect_valid;
    out_instr      = fifo_empty ? 32'h0 : mem_instr_q[rd_idx];
    out_pc         = fifo_empty ? 32'h0 : mem_pc_q[rd_idx];
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    discard_cnt_d = discard_cnt_q;
    outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(rsp_accept);

    if (redirect_valid) begin
      fetch_pc_d    = redirect_target;
      rsp_pc_d      = redirect_target;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      // Everything still in flight belongs to the old stream, including a response that
      // arrives in this very cycle (it is dropped here, not counted).
      discard_cnt_d = outstanding_q - CntW'(rsp_accept);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (rsp_accept) begin
        unique case (state)
          StDrain: discard_cnt_d = discard_cnt_q - CntW'(1);
          StFetch: begin
            rsp_pc_d = rsp_pc_q + 32'd4;
            wr_ptr_d = wr_ptr_q + CntW'(1);
          end
          default: discard_cnt_d = discard_cnt_q;
        endcase
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      outstanding_q <= '0;
      discard_cnt_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      outstanding_q <= outstanding_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rsp_push) begin
      mem_instr_q[wr_idx] <= imem_rsp_data;
      mem_pc_q[wr_idx]    <= rsp_pc_q;
    end
  end

endmodule
